// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
//   - geometry: NUM_LINES lines of BLOCK_BYTES bytes, 8-bit byte address
//   - FSM state encoding for the miss sequencer
//   - addr_t / split_addr: break a CPU byte address into tag/index/offset
package dcache_pkg;

  localparam int NUM_LINES   = 8;
  localparam int BLOCK_BYTES = 4;
  localparam int ADDR_W      = 8;
  localparam int INDEX_W     = $clog2(NUM_LINES);
  localparam int OFFSET_W    = $clog2(BLOCK_BYTES);
  localparam int TAG_W       = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W      = 8 * BLOCK_BYTES;
  localparam int MADDR_W     = TAG_W + INDEX_W;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ALLOCATE  = 2'd2;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } addr_t;

  function automatic addr_t split_addr(input logic [ADDR_W-1:0] a);
    addr_t f;
    f.tag    = a[ADDR_W-1 -: TAG_W];
    f.index  = a[OFFSET_W +: INDEX_W];
    f.offset = a[OFFSET_W-1:0];
    return f;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage for the data cache: valid, dirty, tag and data per line.
//   clk, rst_n      : clock, synchronous active-low reset (clears valid/dirty only)
//   rd_index        : combinational read port -> rd_valid/rd_dirty/rd_tag/rd_data
//   byte_we         : store one byte (wr_index, wr_offset, wr_byte), marks line dirty
//   fill_we         : install a whole line (wr_index, fill_tag, fill_data), valid & clean
module dcache_array
  import dcache_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [INDEX_W-1:0]                  rd_index,
  output logic                                rd_valid,
  output logic                                rd_dirty,
  output logic [TAG_W-1:0]                    rd_tag,
  output logic [BLOCK_BYTES-1:0][7:0]         rd_data,
  input  logic                                byte_we,
  input  logic                                fill_we,
  input  logic [INDEX_W-1:0]                  wr_index,
  input  logic [OFFSET_W-1:0]                 wr_offset,
  input  logic [7:0]                          wr_byte,
  input  logic [TAG_W-1:0]                    fill_tag,
  input  logic [BLOCK_BYTES-1:0][7:0]         fill_data
);

  logic [NUM_LINES-1:0]                       valid;
  logic [NUM_LINES-1:0]                       dirty;
  logic [NUM_LINES-1:0][TAG_W-1:0]            tags;
  logic [NUM_LINES-1:0][BLOCK_BYTES-1:0][7:0] data;

  assign rd_valid = valid[rd_index];
  assign rd_dirty = dirty[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[rd_index];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_we) begin
      valid[wr_index] <= 1'b1;
      dirty[wr_index] <= 1'b0;
    end else if (byte_we) begin
      dirty[wr_index] <= 1'b1;
    end
  end

  // Tag/data have no reset: contents are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tags[wr_index] <= fill_tag;
      data[wr_index] <= fill_data;
    end else if (byte_we) begin
      data[wr_index][wr_offset] <= wr_byte;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
//   CPU side : READ/WRITE/ADDRESS/WRITEDATA in, READDATA/BUSYWAIT out.
//              Hits complete without a stall; misses raise BUSYWAIT.
//   Mem side : mem_read/mem_write strobes (Moore, from state), mem_address
//              {tag,index}, mem_writedata (evicted line), mem_readdata,
//              mem_busywait.
//   CLK, RESET (synchronous, active low).
module dcache_controller
  import dcache_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                READ,
  input  logic                WRITE,
  input  logic [ADDR_W-1:0]   ADDRESS,
  input  logic [7:0]          WRITEDATA,
  output logic [7:0]          READDATA,
  output logic                BUSYWAIT,
  output logic                mem_read,
  output logic                mem_write,
  output logic [MADDR_W-1:0]  mem_address,
  output logic [LINE_W-1:0]   mem_writedata,
  input  logic [LINE_W-1:0]   mem_readdata,
  input  logic                mem_busywait
);

  logic [1:0]                 state;
  logic [TAG_W-1:0]           lat_tag;
  logic [INDEX_W-1:0]         lat_index;
  logic                       seen_busy;

  addr_t                      a;
  logic                       in_idle, req, hit, done;
  logic [INDEX_W-1:0]         idx;
  logic                       line_valid, line_dirty;
  logic [TAG_W-1:0]           line_tag;
  logic [BLOCK_BYTES-1:0][7:0] line_data;
  logic                       byte_we, fill_we;

  assign a       = split_addr(ADDRESS);
  assign in_idle = (state == IDLE);
  assign req     = READ | WRITE;
  // During a miss the latched index governs, so ADDRESS may wander freely.
  assign idx     = in_idle ? a.index : lat_index;
  assign hit     = line_valid && (line_tag == a.tag);
  // Memory handshake completes on a low busy after a high one was seen.
  assign done    = seen_busy && !mem_busywait;

  // READ wins when both request lines are high, so store only on WRITE alone.
  assign byte_we = RESET && in_idle && WRITE && !READ && hit;
  assign fill_we = RESET && (state == ALLOCATE) && done;

  dcache_array u_array (
    .clk       (CLK),
    .rst_n     (RESET),
    .rd_index  (idx),
    .rd_valid  (line_valid),
    .rd_dirty  (line_dirty),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .byte_we   (byte_we),
    .fill_we   (fill_we),
    .wr_index  (idx),
    .wr_offset (a.offset),
    .wr_byte   (WRITEDATA),
    .fill_tag  (lat_tag),
    .fill_data (mem_readdata)
  );

  assign READDATA      = (in_idle && READ && hit) ? line_data[a.offset] : 8'h00;
  assign BUSYWAIT      = in_idle ? (req && !hit) : 1'b1;
  assign mem_write     = (state == WRITEBACK);
  assign mem_read      = (state == ALLOCATE);
  assign mem_writedata = mem_write ? line_data : '0;

  always_comb begin
    mem_address = '0;
    case (state)
      WRITEBACK: mem_address = {line_tag, lat_index};
      ALLOCATE:  mem_address = {lat_tag, lat_index};
      default:   mem_address = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= IDLE;
      seen_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            lat_tag   <= a.tag;
            lat_index <= a.index;
            seen_busy <= 1'b0;
            state     <= (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (done) begin
            state     <= ALLOCATE;
            seen_busy <= 1'b0;
          end else if (mem_busywait) begin
            seen_busy <= 1'b1;
          end
        end
        ALLOCATE: begin
          if (done) begin
            state     <= IDLE;
            seen_busy <= 1'b0;
          end else if (mem_busywait) begin
            seen_busy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        READ = 1'b0, WRITE = 1'b0;
  logic [7:0]  ADDRESS = 8'h00, WRITEDATA = 8'h00;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 32'h0;
  logic        mem_busywait = 1'b0;

  dcache_controller dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- memory model: busy for two sampled edges, then done
  logic [31:0] mem [64];
  int          mcnt = 0;
  logic [7:0]  mkey = 8'h00;

  always @(negedge CLK) begin
    if (!(mem_read || mem_write)) begin
      mcnt = 0;
      mem_busywait = 1'b0;
    end else begin
      if ({mem_read, mem_write, mem_address} != mkey) mcnt = 0;
      mcnt++;
      if (mcnt < 3) mem_busywait = 1'b1;
      else begin
        mem_busywait = 1'b0;
        if (mcnt == 3) begin
          if (mem_write) mem[mem_address] = mem_writedata;
          else           mem_readdata = mem[mem_address];
        end
      end
    end
    mkey = {mem_read, mem_write, mem_address};
  end

  // ---------------- scoreboards
  typedef struct packed { logic wr; logic [5:0] addr; logic [31:0] wdata; } mop_t;
  logic [7:0] cpu_q[$];
  mop_t       mem_q[$];
  logic [7:0] okey = 8'h00;

  // CPU monitor: a request completes on any cycle it is presented unstalled.
  always @(negedge CLK) begin
    if (RESET && (READ || WRITE) && !BUSYWAIT) begin
      if (cpu_q.size() == 0) begin
        total++; bad++;
        $display("FAIL cpu_unexpected: addr %h data %h", ADDRESS, READDATA);
      end else begin
        logic [7:0] e;
        e = cpu_q.pop_front();
        chk($sformatf("readdata@%h", ADDRESS), {24'h0, READDATA}, {24'h0, e});
      end
    end
  end

  // Memory monitor: one expectation per new strobe/address combination.
  always @(negedge CLK) begin
    if ((mem_read || mem_write) && {mem_read, mem_write, mem_address} != okey) begin
      if (mem_q.size() == 0) begin
        total++; bad++;
        $display("FAIL mem_unexpected: wr=%0d addr %h", mem_write, mem_address);
      end else begin
        mop_t e;
        e = mem_q.pop_front();
        chk("mem_op_is_write", {31'h0, mem_write}, {31'h0, e.wr});
        chk("mem_op_is_read",  {31'h0, mem_read},  {31'h0, ~e.wr});
        chk("mem_address", {26'h0, mem_address}, {26'h0, e.addr});
        if (e.wr) chk("mem_writedata", mem_writedata, e.wdata);
      end
    end
    okey = {mem_read, mem_write, mem_address};
  end

  task automatic exp_mem(input logic wr, input logic [5:0] ad, input logic [31:0] wd);
    mop_t m;
    m.wr = wr; m.addr = ad; m.wdata = wd;
    mem_q.push_back(m);
  endtask

  // One CPU access held until it completes; expected READDATA on completion.
  task automatic access(input logic rd, input logic wr, input logic [7:0] ad,
                        input logic [7:0] wd, input logic [7:0] exp, input logic miss);
    int n;
    @(posedge CLK); #1;
    READ = rd; WRITE = wr; ADDRESS = ad; WRITEDATA = wd;
    cpu_q.push_back(exp);
    @(negedge CLK);
    chk($sformatf("busy_first@%h", ad), {31'h0, BUSYWAIT}, {31'h0, miss});
    n = 0;
    while (BUSYWAIT && n < 40) begin @(negedge CLK); n++; end
    if (BUSYWAIT) begin
      total++; bad++;
      $display("FAIL timeout@%h: busywait still 1 want 0", ad);
    end
  endtask

  task automatic idle_cpu();
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 32'h0;
    mem[6'h09] = 32'hDDCCBBAA;
    mem[6'h11] = 32'h77665544;
    mem[6'h02] = 32'h87654321;
    mem[6'h0A] = 32'hA1B2C3D4;

    // reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busywait", {31'h0, BUSYWAIT}, 32'h0);
    chk("rst_mem_read", {31'h0, mem_read}, 32'h0);
    chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
    chk("rst_readdata", {24'h0, READDATA}, 32'h0);
    chk("rst_mem_address", {26'h0, mem_address}, 32'h0);
    chk("rst_mem_writedata", mem_writedata, 32'h0);
    @(posedge CLK); #1 RESET = 1'b1;

    // cold read miss, fill, then hit
    exp_mem(1'b0, 6'h09, 32'h0);
    access(1, 0, 8'h24, 8'h00, 8'hAA, 1);
    // write hit, no stall; then read back
    access(0, 1, 8'h25, 8'h11, 8'h00, 0);
    access(1, 0, 8'h25, 8'h00, 8'h11, 0);
    // conflicting read on dirty line: writeback then allocate
    exp_mem(1'b1, 6'h09, 32'hDDCC11AA);
    exp_mem(1'b0, 6'h11, 32'h0);
    access(1, 0, 8'h44, 8'h00, 8'h44, 1);
    // write miss on an invalid line: allocate only, then store
    exp_mem(1'b0, 6'h02, 32'h0);
    access(0, 1, 8'h08, 8'h5A, 8'h00, 1);
    access(1, 0, 8'h08, 8'h00, 8'h5A, 0);
    access(1, 0, 8'h09, 8'h00, 8'h43, 0);
    // that line is now dirty: evicting it writes back the stored byte
    exp_mem(1'b1, 6'h02, 32'h8765435A);
    exp_mem(1'b0, 6'h0A, 32'h0);
    access(1, 0, 8'h28, 8'h00, 8'hD4, 1);
    // READ and WRITE together on a hit: treated as a read
    access(1, 1, 8'h45, 8'hFF, 8'h55, 0);
    access(1, 0, 8'h45, 8'h00, 8'h55, 0);
    // line stayed clean: eviction needs no writeback
    exp_mem(1'b0, 6'h09, 32'h0);
    access(1, 0, 8'h25, 8'h00, 8'h11, 1);

    // reset in the middle of ALLOCATE
    exp_mem(1'b0, 6'h11, 32'h0);
    @(posedge CLK); #1;
    READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h44;
    @(negedge CLK);
    chk("abort_busy_first", {31'h0, BUSYWAIT}, 32'h1);
    @(negedge CLK);
    chk("abort_mem_read_before", {31'h0, mem_read}, 32'h1);
    RESET = 1'b0; READ = 1'b0;
    @(negedge CLK);
    chk("abort_mem_read_after", {31'h0, mem_read}, 32'h0);
    chk("abort_busywait_after", {31'h0, BUSYWAIT}, 32'h0);
    chk("abort_mem_address", {26'h0, mem_address}, 32'h0);
    @(posedge CLK); #1 RESET = 1'b1;
    // valid bits were cleared, so this misses again
    exp_mem(1'b0, 6'h11, 32'h0);
    access(1, 0, 8'h44, 8'h00, 8'h44, 1);
    idle_cpu();
    repeat (3) @(negedge CLK);

    chk("cpu_q_drained", cpu_q.size(), 32'h0);
    chk("mem_q_drained", mem_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
